// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU data
// port (port 0) and the debug/program loader (port 1), one access at a time.
module mem_bus_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_bytes,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_bytes,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] memaddr,
  output logic [31:0] memin,
  output logic        memwrite,
  output logic [3:0]  iobytes,
  input  logic [31:0] memout,
  output logic        owner,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a requester raises req with stable fields and holds it until the
  // single-cycle ack; it may drop or change req only at the edge ending that ack.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic        is_write_q, is_write_d;
  logic [31:0] memaddr_q, memaddr_d;
  logic [31:0] memin_q, memin_d;
  logic        memwrite_q, memwrite_d;
  logic [3:0]  iobytes_q, iobytes_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        busy_q, busy_d;

  logic        winner;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_bytes;
  logic        capture;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    is_write_d   = is_write_q;
    memaddr_d    = memaddr_q;
    memin_d      = memin_q;
    iobytes_d    = iobytes_q;
    memwrite_d   = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    capture      = 1'b0;

    // On a tie the port that did not win last time gets the bus.
    if (m0_req && m1_req) begin
      winner = ~last_grant_q;
    end else begin
      winner = m1_req;
    end
    sel_write = winner ? m1_write : m0_write;
    sel_addr  = winner ? m1_addr  : m0_addr;
    sel_wdata = winner ? m1_wdata : m0_wdata;
    sel_bytes = winner ? m1_bytes : m0_bytes;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d      = S_ACCESS;
          cnt_d        = 3'd1;
          owner_d      = winner;
          last_grant_d = winner;
          is_write_d   = sel_write;
          memaddr_d    = sel_addr;
          memin_d      = sel_wdata;
          iobytes_d    = sel_bytes;
          if (sel_write) begin
            // A write with no byte lanes still completes, it just never strobes.
            memwrite_d = |sel_bytes;
            if (winner) begin
              ack1_d = 1'b1;
            end else begin
              ack0_d = 1'b1;
            end
          end
        end
      end
      S_ACCESS: begin
        if (is_write_q) begin
          state_d = S_IDLE;
        end else if (RD_LAT == 1) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (capture) begin
      if (owner_q) begin
        rdata1_d = memout;
        ack1_d   = 1'b1;
      end else begin
        rdata0_d = memout;
        ack0_d   = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      is_write_q   <= 1'b0;
      memaddr_q    <= 32'd0;
      memin_q      <= 32'd0;
      memwrite_q   <= 1'b0;
      iobytes_q    <= 4'd0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= 32'd0;
      rdata1_q     <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      is_write_q   <= is_write_d;
      memaddr_q    <= memaddr_d;
      memin_q      <= memin_d;
      memwrite_q   <= memwrite_d;
      iobytes_q    <= iobytes_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  assign m0_ack      = ack0_q;
  assign m1_ack      = ack1_q;
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign memaddr     = memaddr_q;
  assign memin       = memin_q;
  assign memwrite    = memwrite_q;
  assign iobytes     = iobytes_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with RD_LAT=3 carries most
// of the sequence, a second with RD_LAT=1 checks the short read path.
module tb_mem_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (RD_LAT=3) ----------------
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_bytes, m1_bytes;
  logic        m0_ack, m1_ack, memwrite, owner, busy;
  logic [31:0] m0_rdata, m1_rdata, memaddr, memin, memout;
  logic [3:0]  iobytes;
  logic [1:0]  dbg_state;

  // ---------------- second DUT (RD_LAT=1) ----------------
  logic        l1_m0_req, l1_m0_write, l1_m1_req, l1_m1_write;
  logic [31:0] l1_m0_addr, l1_m0_wdata, l1_m1_addr, l1_m1_wdata;
  logic [3:0]  l1_m0_bytes, l1_m1_bytes;
  logic        l1_m0_ack, l1_m1_ack, l1_memwrite, l1_owner, l1_busy;
  logic [31:0] l1_m0_rdata, l1_m1_rdata, l1_memaddr, l1_memin, l1_memout;
  logic [3:0]  l1_iobytes;
  logic [1:0]  l1_dbg_state;

  // Memory read model: fixed pattern at 0x40, address-derived data elsewhere.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h40) return 32'h1234_5678;
    return a ^ 32'hA5A5_0000;
  endfunction

  assign memout    = mem_model(memaddr);
  assign l1_memout = mem_model(l1_memaddr);

  mem_bus_arbiter #(.RD_LAT(3)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_bytes(m0_bytes), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_bytes(m1_bytes), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .memaddr(memaddr), .memin(memin), .memwrite(memwrite), .iobytes(iobytes),
    .memout(memout), .owner(owner), .busy(busy), .dbg_state_o(dbg_state)
  );

  mem_bus_arbiter #(.RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .m0_req(l1_m0_req), .m0_write(l1_m0_write), .m0_addr(l1_m0_addr),
    .m0_wdata(l1_m0_wdata), .m0_bytes(l1_m0_bytes), .m0_ack(l1_m0_ack),
    .m0_rdata(l1_m0_rdata),
    .m1_req(l1_m1_req), .m1_write(l1_m1_write), .m1_addr(l1_m1_addr),
    .m1_wdata(l1_m1_wdata), .m1_bytes(l1_m1_bytes), .m1_ack(l1_m1_ack),
    .m1_rdata(l1_m1_rdata),
    .memaddr(l1_memaddr), .memin(l1_memin), .memwrite(l1_memwrite),
    .iobytes(l1_iobytes), .memout(l1_memout), .owner(l1_owner), .busy(l1_busy),
    .dbg_state_o(l1_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
    m0_req = req; m0_write = wr; m0_addr = a; m0_wdata = d; m0_bytes = b;
  endtask

  task automatic drive_m1(input logic req, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
    m1_req = req; m1_write = wr; m1_addr = a; m1_wdata = d; m1_bytes = b;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " memaddr"},  memaddr,  32'h0);
    chk({tag, " memin"},    memin,    32'h0);
    chk({tag, " memwrite"}, memwrite, 32'h0);
    chk({tag, " iobytes"},  iobytes,  32'h0);
    chk({tag, " m0_ack"},   m0_ack,   32'h0);
    chk({tag, " m1_ack"},   m1_ack,   32'h0);
    chk({tag, " m0_rdata"}, m0_rdata, 32'h0);
    chk({tag, " m1_rdata"}, m1_rdata, 32'h0);
    chk({tag, " owner"},    owner,    32'h0);
    chk({tag, " busy"},     busy,     32'h0);
    chk({tag, " state"},    dbg_state, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    drive_m0(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    drive_m1(1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 4'h3);
    l1_m0_req = 1'b0; l1_m0_write = 1'b0; l1_m0_addr = 32'h0; l1_m0_wdata = 32'h0; l1_m0_bytes = 4'h0;
    l1_m1_req = 1'b0; l1_m1_write = 1'b0; l1_m1_addr = 32'h0; l1_m1_wdata = 32'h0; l1_m1_bytes = 4'h0;

    // Reset held with both requests pending.
    step(); step(); step();
    chk_reset_outputs("reset");
    chk("reset l1 busy", l1_busy, 32'h0);

    // Release: continuous writes from both ports alternate 0,1,0,1 with turnaround.
    rst = 1'b1;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [0:0] exp_owner;
      step();
      chk($sformatf("rr[%0d] one ack", i), {31'd0, m0_ack & m1_ack}, 32'h0);
      if (i % 2 == 0) begin
        exp_owner = exp_q.pop_front();
        chk($sformatf("rr[%0d] busy", i), busy, 32'h1);
        chk($sformatf("rr[%0d] owner", i), owner, {31'd0, exp_owner});
        chk($sformatf("rr[%0d] ack of owner", i), exp_owner ? m1_ack : m0_ack, 32'h1);
        chk($sformatf("rr[%0d] memwrite", i), memwrite, 32'h1);
        chk($sformatf("rr[%0d] memaddr", i), memaddr, exp_owner ? 32'h200 : 32'h100);
        chk($sformatf("rr[%0d] memin", i), memin, exp_owner ? 32'hCAFE_F00D : 32'hDEAD_BEEF);
        chk($sformatf("rr[%0d] iobytes", i), iobytes, exp_owner ? 32'h3 : 32'hF);
      end else begin
        chk($sformatf("rr[%0d] idle busy", i), busy, 32'h0);
        chk($sformatf("rr[%0d] idle acks", i), {30'd0, m1_ack, m0_ack}, 32'h0);
        chk($sformatf("rr[%0d] idle memwrite", i), memwrite, 32'h0);
        chk($sformatf("rr[%0d] idle memaddr hold", i), memaddr, (i % 4 == 1) ? 32'h100 : 32'h200);
      end
    end
    chk("rr queue drained", exp_q.size(), 32'h0);
    drive_m0(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    drive_m1(1'b0, 1'b1, 32'h200, 32'hCAFE_F00D, 4'h3);

    // Zero-byte write: completes without strobing memory.
    drive_m0(1'b1, 1'b1, 32'h300, 32'h1111_1111, 4'h0);
    step();
    chk("zb m0_ack", m0_ack, 32'h1);
    chk("zb memwrite", memwrite, 32'h0);
    chk("zb iobytes", iobytes, 32'h0);
    chk("zb memaddr", memaddr, 32'h300);
    chk("zb memin", memin, 32'h1111_1111);
    m0_req = 1'b0;
    step();
    chk("zb ack done", m0_ack, 32'h0);
    chk("zb busy done", busy, 32'h0);
    chk("zb memwrite done", memwrite, 32'h0);

    // Port 1 read with RD_LAT=3: ack three edges after the request edge.
    drive_m1(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    step();
    chk("rd3 e0 owner", owner, 32'h1);
    chk("rd3 e0 state", dbg_state, 32'h1);
    chk("rd3 e0 memwrite", memwrite, 32'h0);
    chk("rd3 e0 memaddr", memaddr, 32'h40);
    chk("rd3 e0 ack", m1_ack, 32'h0);
    step();
    chk("rd3 e1 state", dbg_state, 32'h2);
    chk("rd3 e1 ack", m1_ack, 32'h0);
    step();
    chk("rd3 e2 ack", m1_ack, 32'h0);
    step();
    chk("rd3 e3 ack", m1_ack, 32'h1);
    chk("rd3 e3 rdata", m1_rdata, 32'h1234_5678);
    chk("rd3 e3 m0_ack", m0_ack, 32'h0);
    chk("rd3 e3 m0_rdata", m0_rdata, 32'h0);
    chk("rd3 e3 state", dbg_state, 32'h3);
    m1_req = 1'b0;
    step();
    chk("rd3 e4 ack", m1_ack, 32'h0);
    chk("rd3 e4 busy", busy, 32'h0);
    chk("rd3 e4 rdata hold", m1_rdata, 32'h1234_5678);

    // Port 1 read with RD_LAT=1 on the second instance.
    l1_m1_req = 1'b1; l1_m1_write = 1'b0; l1_m1_addr = 32'h40; l1_m1_bytes = 4'hF;
    step();
    chk("rd1 e0 ack", l1_m1_ack, 32'h0);
    chk("rd1 e0 state", l1_dbg_state, 32'h1);
    step();
    chk("rd1 e1 ack", l1_m1_ack, 32'h1);
    chk("rd1 e1 rdata", l1_m1_rdata, 32'h1234_5678);
    chk("rd1 e1 m0_ack", l1_m0_ack, 32'h0);
    chk("rd1 e1 m0_rdata", l1_m0_rdata, 32'h0);
    l1_m1_req = 1'b0;
    step();
    chk("rd1 e2 ack", l1_m1_ack, 32'h0);
    chk("rd1 e2 busy", l1_busy, 32'h0);

    // Reset while a port 0 read sits in WAIT, then the read is reissued.
    drive_m0(1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
    step();
    chk("rst e0 state", dbg_state, 32'h1);
    chk("rst e0 owner", owner, 32'h0);
    step();
    chk("rst e1 state", dbg_state, 32'h2);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    step();
    chk("midrst held ack", m0_ack, 32'h0);
    chk("midrst held busy", busy, 32'h0);
    rst = 1'b1;
    step();
    chk("reissue e0 state", dbg_state, 32'h1);
    chk("reissue e0 memaddr", memaddr, 32'h44);
    step();
    chk("reissue e1 ack", m0_ack, 32'h0);
    step();
    chk("reissue e2 ack", m0_ack, 32'h0);
    step();
    chk("reissue e3 ack", m0_ack, 32'h1);
    chk("reissue e3 rdata", m0_rdata, 32'hA5A5_0044);
    chk("reissue e3 m1_rdata", m1_rdata, 32'h0);
    chk("reissue e3 m1_ack", m1_ack, 32'h0);
    m0_req = 1'b0;
    step();
    chk("reissue e4 ack", m0_ack, 32'h0);
    chk("reissue e4 state", dbg_state, 32'h0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port data memory (memaddr/memin/memout/memwrite/iobytes) between two requesters: port 0 = CPU data port, port 1 = debug/program loader.
- Round-robin arbitration, one outstanding access at a time, configurable memory read latency.
- Sits between the CPU core and the data RAM at SoC top level; instruction fetch (romaddr/romout) is not arbitrated here.

Parameters:
- RD_LAT, 1, memory read latency in clock edges from address valid to memout valid; legal 1..4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- m0_req  in  1  port 0 request; held high until m0_ack
- m0_write  in  1  port 0 1=write, 0=read
- m0_addr  in  32  port 0 byte address
- m0_wdata  in  32  port 0 write data
- m0_bytes  in  4  port 0 byte-lane enables
- m0_ack  out  1  port 0 one-cycle completion pulse
- m0_rdata  out  32  port 0 read data, valid while m0_ack=1
- m1_req, m1_write, m1_addr, m1_wdata, m1_bytes, m1_ack, m1_rdata: same as port 0
- memaddr  out  32  memory address
- memin  out  32  memory write data
- memwrite  out  1  memory write strobe
- iobytes  out  4  memory byte-lane enables
- memout  in  32  memory read data
- owner  out  1  port owning the current/last access
- busy  out  1  1 when FSM not in IDLE

Behaviour:
- Reset (rst=0, async): FSM=IDLE; memaddr=0, memin=0, memwrite=0, iobytes=0, m0/m1_ack=0, m0/m1_rdata=0, owner=0, busy=0, last_grant=1 (so port 0 wins first tie).
- All outputs are registered. Requester contract: fields stable while req=1; req dropped or changed only at the edge ending its ack cycle.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: at edge E0 with any req=1, select winner. One requester -> it. Both -> port != last_grant. Load memaddr/memin/iobytes from winner, set owner and last_grant=winner.
  - Write -> ACCESS with memwrite=1 and winner ack=1, unless bytes==0: memwrite=0, ack still 1.
  - Read -> ACCESS with memwrite=0.
- ACCESS, write: lasts exactly one cycle; next edge -> IDLE, memwrite=0, ack=0.
- ACCESS, read: counter=1.
  - RD_LAT=1: next edge captures memout into winner rdata, ack=1 -> RESP.
  - Else -> WAIT.
- WAIT: counter increments each edge; on the edge where counter reaches RD_LAT, capture memout, ack=1 -> RESP.
- RESP: one cycle with ack=1; next edge -> IDLE, ack=0.
- Latency from request-sampling edge E0 to ack visible:
  - Write: after E0 (1 cycle).
  - Read: after edge E0+RD_LAT.
- After every completion FSM spends at least one cycle in IDLE (turnaround). Max throughput: one write per 2 cycles, one read per RD_LAT+2 cycles.
- memaddr/memin/iobytes hold their last values in IDLE; iobytes cleared to 0 only at reset. memwrite is high only in a write ACCESS cycle.
- rdata of each port holds its last captured value; the non-owning port's rdata and ack are untouched.
- Address and byte lanes pass through unchanged; no alignment checks.
- A req arriving while busy=1 waits; a req that rises during the IDLE turnaround is arbitrated at the end of that cycle.
- Only one ack is ever high per cycle.
- rst asserted mid-access: immediate abort to reset values, no ack issued; the requester must reissue.

Test Plan:
- Reset: hold rst=0 with both reqs high -> all outputs 0, busy=0; release -> port 0 granted first (owner=0).
- Single write: m0 write addr=0x100, wdata=0xDEADBEEF, bytes=4'hF -> next cycle memaddr=0x100, memin=0xDEADBEEF, iobytes=4'hF, memwrite=1 and m0_ack=1 for exactly one cycle, then IDLE.
- Read, RD_LAT=1 and RD_LAT=3: m1 read addr=0x40, memout model returns 0x12345678 -> m1_rdata=0x12345678 with m1_ack after 1 and 3 edges respectively; m0_rdata unchanged.
- Contention: both ports issue continuous writes -> grants alternate 0,1,0,1, one IDLE cycle between accesses, never two acks in one cycle.
- Zero-byte write: m0 write bytes=4'h0 -> memwrite stays 0, m0_ack pulses once.
- Reset mid-read (RD_LAT=3): assert rst=0 in WAIT -> no ack, outputs cleared; after release the reissued read completes normally.
